// File: rtl/drum_sweep_ctrl_pkg.sv
// Shared definitions for the drum sweep controller: FSM encoding and geometry defaults.
package drum_sweep_ctrl_pkg;

  localparam int unsigned NUM_ROWS_DEF   = 30;
  localparam int unsigned CENTER_ROW_DEF = 15;
  localparam int unsigned ROW_W          = 5;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOAD   = 3'd4,
    ST_COMMIT = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/drum_sweep_ctrl_row_seq.sv
// Row counter for the drum column sweep, with first/last row decodes.
module drum_row_seq
  import drum_sweep_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS = NUM_ROWS_DEF
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [ROW_W-1:0] row_idx,
  output logic             row0,
  output logic             top
);

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      row_idx <= '0;
    end else if (clr) begin
      row_idx <= '0;
    end else if (inc) begin
      row_idx <= row_idx + 1'b1;
    end
  end

  assign row0 = (row_idx == '0);
  assign top  = (row_idx == ROW_W'(NUM_ROWS - 1));

endmodule

// File: rtl/drum_sweep_ctrl.sv
// Sweep sequencer: walks the column row by row per codec request and publishes the center sample.
module drum_sweep_ctrl
  import drum_sweep_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS   = NUM_ROWS_DEF,
  parameter int unsigned CENTER_ROW = CENTER_ROW_DEF
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               sample_req,
  input  logic signed [17:0] center_u,
  input  logic               sample_ready,
  output logic               init_en,
  output logic [ROW_W-1:0]   row_idx,
  output logic [ROW_W-1:0]   rd_addr,
  output logic [ROW_W-1:0]   rd_addr_prev,
  output logic [ROW_W-1:0]   wr_addr,
  output logic               we,
  output logic               we_prev,
  output logic               load_en,
  output logic               commit_en,
  output logic               row0,
  output logic               top,
  output logic signed [17:0] sample,
  output logic               sample_valid,
  output logic               overrun,
  output logic [31:0]        sweep_cycles
);

  state_t             state, state_nxt;
  logic               started;
  logic               pending;
  logic               row_clr, row_inc;
  logic signed [17:0] captured;
  logic [31:0]        cyc_cnt;

  drum_row_seq #(.NUM_ROWS(NUM_ROWS)) u_row_seq (
    .clk_50  (clk_50),
    .reset   (reset),
    .clr     (row_clr),
    .inc     (row_inc),
    .row_idx (row_idx),
    .row0    (row0),
    .top     (top)
  );

  // INIT is held off for one edge so no enable is asserted while reset is low.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    row_clr      = 1'b0;
    row_inc      = 1'b0;
    init_en      = 1'b0;
    we           = 1'b0;
    we_prev      = 1'b0;
    load_en      = 1'b0;
    commit_en    = 1'b0;
    rd_addr      = '0;
    rd_addr_prev = '0;
    wr_addr      = '0;
    case (state)
      ST_INIT: begin
        if (started) begin
          init_en = 1'b1;
          we      = 1'b1;
          we_prev = 1'b1;
          wr_addr = row_idx;
          if (top) begin
            row_clr   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            row_inc = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (sample_req || pending) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        rd_addr      = top ? row_idx : row_idx + 1'b1;
        rd_addr_prev = row_idx;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: state_nxt = ST_LOAD;
      ST_LOAD: begin
        load_en   = 1'b1;
        state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_en = 1'b1;
        we        = 1'b1;
        we_prev   = 1'b1;
        wr_addr   = row_idx;
        if (top) begin
          row_clr   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          row_inc   = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Counter restarts at 1 on leaving IDLE so it reads the inclusive SETUP..DONE span in DONE.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      pending      <= 1'b0;
      overrun      <= 1'b0;
      captured     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sweep_cycles <= '0;
      cyc_cnt      <= '0;
    end else begin
      if (state == ST_IDLE) begin
        pending <= 1'b0;
      end else if (sample_req) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      if (state == ST_COMMIT && row_idx == ROW_W'(CENTER_ROW)) captured <= center_u;
      cyc_cnt <= (state == ST_IDLE) ? 32'd1 : cyc_cnt + 32'd1;
      if (state == ST_DONE) begin
        sample       <= captured;
        sample_valid <= 1'b1;
        sweep_cycles <= cyc_cnt;
        if (sample_valid && !sample_ready) overrun <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/drum_sweep_ctrl.md
DRUM_SWEEP_CTRL -- requirements
Module: drum_sweep_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 30, rows per column (M10K depth used).
REQ-002 SHALL have parameter CENTER_ROW, default 15, row whose node value is emitted as the audio sample.
REQ-003 SHALL have ports: clk_50 in 1 system clock; reset in 1 asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports: sample_req in 1 codec sample request pulse; center_u in 18 signed 1.17 center node value from datapath; sample_ready in 1 consumer accept.
REQ-005 SHALL have ports: init_en out 1 init phase, datapath loads pyramid; row_idx out 5 current row; rd_addr out 5 curr-M10K read address; rd_addr_prev out 5 prev-M10K read address.
REQ-006 SHALL have ports: wr_addr out 5 write address for both M10Ks; we out 1 curr-M10K write enable; we_prev out 1 prev-M10K write enable.
REQ-007 SHALL have ports: load_en out 1 capture u_up/prev_u; commit_en out 1 shift registers, write next_u; row0 out 1 row==0; top out 1 row==NUM_ROWS-1.
REQ-008 SHALL have ports: sample out 18 signed sample value; sample_valid out 1 sample held; overrun out 1 sticky lost request; sweep_cycles out 32 cycles of last sweep.

Function
REQ-009 SHALL implement states INIT, IDLE, SETUP, WAIT, LOAD, COMMIT, DONE, one state per clock.
REQ-010 INIT SHALL last NUM_ROWS cycles: init_en=1, we=we_prev=1, wr_addr=row_idx counting 0..NUM_ROWS-1, then row_idx<=0, go IDLE.
REQ-011 IDLE SHALL go SETUP when sample_req is high or a pending request is latched; otherwise hold, all enables 0.
REQ-012 SETUP SHALL drive rd_addr=row_idx+1 (unchanged when top=1) and rd_addr_prev=row_idx.
REQ-013 WAIT SHALL be one idle cycle covering M10K one-cycle read latency.
REQ-014 LOAD SHALL assert load_en for exactly one cycle.
REQ-015 COMMIT SHALL assert commit_en, we, we_prev for exactly one cycle, wr_addr=row_idx.
REQ-016 In COMMIT with row_idx==CENTER_ROW, center_u SHALL be captured into an internal sample register.
REQ-017 COMMIT SHALL go to SETUP with row_idx+1 when top=0, else to DONE with row_idx<=0.
REQ-018 Per-row latency SHALL be 4 cycles; a full sweep SHALL be 4*NUM_ROWS cycles (120 at default), SETUP of row 0 to COMMIT of last row inclusive.
REQ-019 sweep_cycles SHALL be loaded in DONE with the count from SETUP row 0 through DONE inclusive (121 at default).
REQ-020 DONE SHALL copy the captured value to sample, set sample_valid, go IDLE.
REQ-021 sample_valid SHALL stay high until a cycle with sample_ready=1, then clear; sample SHALL be stable while valid.
REQ-022 If DONE occurs while sample_valid is still high, sample SHALL be overwritten and overrun set.
REQ-023 sample_req outside IDLE SHALL set a one-deep pending flag; a further request while pending is set SHALL set overrun.
REQ-024 IDLE consuming a request SHALL clear pending; simultaneous new sample_req in that cycle SHALL be ignored (same request).
REQ-025 overrun SHALL clear only on reset.
REQ-026 row0 and top SHALL be combinational decodes of row_idx.

Reset
REQ-027 Asserting reset at any time, including mid-sweep, SHALL immediately force state INIT, row_idx=0, all enables 0, rd/wr addresses 0.
REQ-028 Reset SHALL clear sample=0, sample_valid=0, overrun=0, pending=0, sweep_cycles=0.
REQ-029 After reset deassertion, INIT SHALL begin on the first clk_50 edge.

Structure
REQ-030 State encoding (3-bit) and NUM_ROWS/CENTER_ROW defaults SHALL live in a shared drum package.
REQ-031 SHALL be one module plus one sub-module drum_row_seq (row counter with top/row0 decode); datapath, M10Ks excluded.

Verification
REQ-032 Reset release -> 30 INIT cycles, wr_addr 0..29, we=we_prev=1, then IDLE, all enables 0.
REQ-033 One sample_req in IDLE, center_u ramps by cycle -> 30 load_en and 30 commit_en pulses 4 cycles apart, sample equals center_u at row-15 COMMIT, sweep_cycles=121.
REQ-034 sample_req at sweep cycle 50 -> second sweep starts immediately after DONE->IDLE, overrun=0.
REQ-035 Three sample_req in one sweep -> overrun=1, exactly one extra sweep.
REQ-036 sample_ready held 0 across two sweeps -> sample updated to second value, overrun=1; sample_ready=1 clears sample_valid next cycle.
REQ-037 reset low at sweep row 12 -> outputs zero asynchronously, INIT restarts at row 0.
